// File: rtl/bsg_fma_slice_mul_seq_if.sv
// Operand/result handshake bundle for the sliced sequential multiplier.
interface bsg_fma_slice_mul_seq_if #(
  parameter int unsigned width_p = 16
) ();

  logic                   v_i;
  logic [width_p-1:0]     a_i;
  logic [width_p-1:0]     b_i;
  logic                   ready_o;
  logic                   v_o;
  logic [2*width_p-1:0]   data_o;
  logic                   yumi_i;
  logic                   busy_o;

  // Multiplier side: consumes operands and yumi, produces status and result.
  modport slave (
    input  v_i, a_i, b_i, yumi_i,
    output ready_o, v_o, data_o, busy_o
  );

  // Client side: supplies operands, takes results.
  modport master (
    output v_i, a_i, b_i, yumi_i,
    input  ready_o, v_o, data_o, busy_o
  );

endinterface

// File: rtl/bsg_fma_slice_mul_seq.sv
// Iterative unsigned multiplier: one slice_p x slice_p partial product per cycle,
// shift-accumulated into a 2*width_p result. One operation in flight.
module bsg_fma_slice_mul_seq #(
  parameter int unsigned width_p = 16,
  parameter int unsigned slice_p = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bsg_fma_slice_mul_seq_if.slave bus
);

  localparam int unsigned n_lp  = width_p / slice_p;
  localparam int unsigned npp_lp = n_lp * n_lp;
  localparam int unsigned kw_lp = (npp_lp > 1) ? $clog2(npp_lp) : 1;
  localparam int unsigned iw_lp = (n_lp > 1) ? $clog2(n_lp) : 1;
  localparam logic [kw_lp-1:0] k_last_lp = kw_lp'(npp_lp - 1);

  // Operand width must split evenly into slices.
  if ((width_p % slice_p) != 0) begin : g_bad_slice
    $error("bsg_fma_slice_mul_seq: width_p must be a multiple of slice_p");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state;
  logic [kw_lp-1:0]       k;
  logic [2*width_p-1:0]   acc;
  logic [width_p-1:0]     a_r;
  logic [width_p-1:0]     b_r;
  logic                   ready_r;
  logic                   busy_r;
  logic                   v_r;

  logic [iw_lp-1:0]       i_idx;
  logic [iw_lp-1:0]       j_idx;
  logic [slice_p-1:0]     a_sl;
  logic [slice_p-1:0]     b_sl;
  logic [2*slice_p-1:0]   pp;
  logic [2*width_p-1:0]   pp_sh;

  // Select the current slice pair (a slice fastest) and align its product.
  always_comb begin
    i_idx = iw_lp'(32'(k) % n_lp);
    j_idx = iw_lp'(32'(k) / n_lp);
    a_sl  = a_r[32'(i_idx)*slice_p +: slice_p];
    b_sl  = b_r[32'(j_idx)*slice_p +: slice_p];
    pp    = (2*slice_p)'(a_sl) * (2*slice_p)'(b_sl);
    pp_sh = (2*width_p)'(pp) << (slice_p * (32'(i_idx) + 32'(j_idx)));
  end

  // Sequencer: accept, iterate over all slice pairs, hold result until yumi.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      k       <= '0;
      acc     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      v_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.v_i) begin
            a_r     <= bus.a_i;
            b_r     <= bus.b_i;
            acc     <= '0;
            k       <= '0;
            state   <= BUSY;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        BUSY: begin
          acc <= acc + pp_sh;
          if (k == k_last_lp) begin
            k      <= '0;
            state  <= DONE;
            busy_r <= 1'b0;
            v_r    <= 1'b1;
          end else begin
            k <= k + kw_lp'(1);
          end
        end
        DONE: begin
          if (bus.yumi_i) begin
            state   <= IDLE;
            v_r     <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          v_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o = ready_r;
  assign bus.busy_o  = busy_r;
  assign bus.v_o     = v_r;
  assign bus.data_o  = acc;

endmodule

// File: tb/tb_bsg_fma_slice_mul_seq.sv
// Self-checking bench for bsg_fma_slice_mul_seq (16/8 default and 24/8 variant).
module tb_bsg_fma_slice_mul_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bsg_fma_slice_mul_seq_if #(.width_p(16)) bus ();
  bsg_fma_slice_mul_seq_if #(.width_p(24)) bus24 ();

  bsg_fma_slice_mul_seq #(.width_p(16), .slice_p(8)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus.slave)
  );

  bsg_fma_slice_mul_seq #(.width_p(24), .slice_p(8)) dut24 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus24.slave)
  );

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure cycles from accept edge to v_o, stall yumi, retire.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int stall, output logic [31:0] res, output int lat);
    bus.v_i = 1'b1;
    bus.a_i = a;
    bus.b_i = b;
    tick();
    bus.v_i = 1'b0;
    bus.a_i = 16'h0;
    bus.b_i = 16'h0;
    lat = 0;
    while (!bus.v_o && lat < 40) begin
      tick();
      lat++;
    end
    res = bus.data_o;
    for (int s = 0; s < stall; s++) begin
      chk("stall_v", 64'(bus.v_o), 64'd1);
      chk("stall_data", 64'(bus.data_o), 64'(res));
      chk("stall_ready", 64'(bus.ready_o), 64'd0);
      if (s == 3) begin
        bus.v_i = 1'b1;
        bus.a_i = 16'h1111;
        bus.b_i = 16'h1111;
      end else begin
        bus.v_i = 1'b0;
      end
      tick();
    end
    bus.v_i = 1'b0;
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    chk("post_yumi_v", 64'(bus.v_o), 64'd0);
    chk("post_yumi_ready", 64'(bus.ready_o), 64'd1);
  endtask

  initial begin
    logic [31:0] res;
    int lat;
    logic [31:0] q [$];
    logic [31:0] expv;
    int accepts, results, viol;
    logic acc_now, take;

    tbl[0] = '{a: 16'h1234, b: 16'h5678, p: 32'h06260060};
    tbl[1] = '{a: 16'hFFFF, b: 16'hFFFF, p: 32'hFFFE0001};
    tbl[2] = '{a: 16'h0000, b: 16'hBEEF, p: 32'h00000000};
    tbl[3] = '{a: 16'h0002, b: 16'h0003, p: 32'h00000006};

    reset_n = 1'b0;
    bus.v_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.yumi_i = 1'b0;
    bus24.v_i = 1'b0; bus24.a_i = '0; bus24.b_i = '0; bus24.yumi_i = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    chk("rst_v", 64'(bus.v_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_data", 64'(bus.data_o), 64'd0);
    reset_n = 1'b1;
    tick();

    // Table vectors with immediate yumi.
    for (int t = 0; t < 4; t++) begin
      run_op(tbl[t].a, tbl[t].b, 0, res, lat);
      chk("tbl_prod", 64'(res), 64'(tbl[t].p));
      chk("tbl_latency", 64'(lat), 64'd4);
    end

    // Backpressure: result held 10 cycles, stray v_i ignored.
    run_op(16'h00FF, 16'hFF00, 10, res, lat);
    chk("bp_prod", 64'(res), 64'h00FE0100);
    chk("bp_latency", 64'(lat), 64'd4);
    run_op(16'h0002, 16'h0003, 0, res, lat);
    chk("bp_next_prod", 64'(res), 64'h6);

    // Reset in the second BUSY cycle discards the operation.
    bus.v_i = 1'b1; bus.a_i = 16'hABCD; bus.b_i = 16'h1234;
    tick();
    bus.v_i = 1'b0;
    chk("mid_busy", 64'(bus.busy_o), 64'd1);
    tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_v", 64'(bus.v_o), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy_o), 64'd0);
    chk("mid_rst_ready", 64'(bus.ready_o), 64'd1);
    chk("mid_rst_data", 64'(bus.data_o), 64'd0);
    reset_n = 1'b1;
    tick();
    run_op(16'h0010, 16'h0010, 0, res, lat);
    chk("post_rst_prod", 64'(res), 64'h100);

    // Random back-to-back stream against a queue of a*b products.
    accepts = 0; results = 0; viol = 0;
    bus.v_i = 1'b1;
    bus.a_i = 16'($urandom);
    bus.b_i = 16'($urandom);
    for (int cyc = 0; cyc < 3000 && results < 50; cyc++) begin
      if (bus.ready_o && (bus.busy_o || bus.v_o)) viol++;
      acc_now = bus.ready_o && bus.v_i;
      if (acc_now) begin
        q.push_back(32'(bus.a_i) * 32'(bus.b_i));
        accepts++;
      end
      take = 1'b0;
      if (bus.v_o) begin
        bus.yumi_i = ($urandom_range(0, 2) == 0);
        take = bus.yumi_i;
      end else begin
        bus.yumi_i = 1'b0;
      end
      if (take) begin
        if (q.size() == 0) begin
          chk("rand_spurious_v", 64'(bus.data_o), 64'hDEAD_0000_0000_0000);
        end else begin
          expv = q.pop_front();
          chk("rand_prod", 64'(bus.data_o), 64'(expv));
        end
        results++;
      end
      tick();
      if (acc_now) begin
        if (accepts < 50) begin
          bus.a_i = 16'($urandom);
          bus.b_i = 16'($urandom);
        end else begin
          bus.v_i = 1'b0;
        end
      end
    end
    bus.v_i = 1'b0;
    bus.yumi_i = 1'b0;
    chk("rand_accepts", 64'(accepts), 64'd50);
    chk("rand_results", 64'(results), 64'd50);
    chk("rand_overlap", 64'(viol), 64'd0);
    chk("rand_queue_empty", 64'(q.size()), 64'd0);
    tick();

    // 24-bit variant: nine partial products.
    bus24.v_i = 1'b1; bus24.a_i = 24'hFFFFFF; bus24.b_i = 24'h000002;
    tick();
    bus24.v_i = 1'b0;
    lat = 0;
    while (!bus24.v_o && lat < 60) begin
      tick();
      lat++;
    end
    chk("w24_latency", 64'(lat), 64'd9);
    chk("w24_prod", 64'(bus24.data_o), 64'h0000_01FF_FFFE);
    bus24.yumi_i = 1'b1;
    tick();
    bus24.yumi_i = 1'b0;
    chk("w24_ready", 64'(bus24.ready_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
